// File: rtl/midi_uart_receiver.sv
// MIDI 8-N-1 serial receiver: 31 250 baud line to byte + one-cycle strobe.
// Optional build macro: MIDI_RX_MAJORITY_VOTE_EN (2-of-3 vote per bit sample).
module midi_uart_receiver #(
  parameter int CLOCK_HZ = 50_000_000,
  parameter int BAUD     = 31_250
) (
  input  logic       clock_50_000_000,
  input  logic       reset,
  input  logic       midi_rx,
  output logic [7:0] data_out,
  output logic       data_out_ready,
  output logic       framing_error,
  output logic       busy
);

  localparam int CYCLES_PER_BIT = CLOCK_HZ / BAUD;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  if (CYCLES_PER_BIT < 16) begin : g_rate_check
    $error("midi_uart_receiver: CLOCK_HZ/BAUD must be at least 16");
  end

  logic             sync_1;
  logic             rx_sync;
  logic             sample;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift_reg;

  // Both flops reset high so an idle line is not mistaken for a start bit.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      sync_1  <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      sync_1  <= midi_rx;
      rx_sync <= sync_1;
    end
  end

`ifdef MIDI_RX_MAJORITY_VOTE_EN
  // hist[0] is rx_sync one cycle before the target, hist[1] two cycles before.
  logic [1:0] hist;

  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) hist <= 2'b11;
    else       hist <= {hist[0], rx_sync};
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & rx_sync) | (hist[0] & rx_sync);
`else
  assign sample = rx_sync;
`endif

  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      idx            <= 3'd0;
      shift_reg      <= 8'h00;
      data_out       <= 8'h00;
      data_out_ready <= 1'b0;
      framing_error  <= 1'b0;
    end else begin
      data_out_ready <= 1'b0;
      framing_error  <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          idx <= 3'd0;
          if (!rx_sync) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= 3'd0;
            // A high line at mid-start-bit means the falling edge was a glitch.
            state <= sample ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt       <= '0;
            shift_reg <= {sample, shift_reg[7:1]};
            idx       <= idx + 3'd1;
            if (idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (sample) begin
              data_out       <= shift_reg;
              data_out_ready <= 1'b1;
              state          <= S_IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          cnt <= '0;
          if (rx_sync) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_midi_uart_receiver.sv
// Directed bench for midi_uart_receiver at 160 clocks per bit (short run time).
module tb_midi_uart_receiver;

  localparam int CLK_HZ = 5_000_000;
  localparam int BAUD   = 31_250;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;
  // Line driven low at a negedge with edge count s -> pulse seen at edge s+LAT.
  localparam int LAT    = HALF + 9 * CPB + 3;
  localparam int FRAME  = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       midi_rx;
  logic [7:0] data_out;
  logic       data_out_ready;
  logic       framing_error;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  int         edge_cnt = 0;
  int         rdy_t[$];
  logic [7:0] rdy_d[$];
  int         fe_t[$];
  int         rise_t[$];
  int         fall_t[$];
  int         overlap = 0;
  logic       prev_busy = 1'b0;

  midi_uart_receiver #(.CLOCK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clock_50_000_000(clk),
    .reset(reset),
    .midi_rx(midi_rx),
    .data_out(data_out),
    .data_out_ready(data_out_ready),
    .framing_error(framing_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    edge_cnt++;
    if (data_out_ready) begin
      rdy_t.push_back(edge_cnt);
      rdy_d.push_back(data_out);
    end
    if (framing_error) fe_t.push_back(edge_cnt);
    if (data_out_ready && framing_error) overlap++;
    if (busy && !prev_busy) rise_t.push_back(edge_cnt);
    if (!busy && prev_busy) fall_t.push_back(edge_cnt);
    prev_busy = busy;
  end

  task automatic clear_log();
    rdy_t.delete(); rdy_d.delete(); fe_t.delete(); rise_t.delete(); fall_t.delete();
  endtask

  // Drives one frame, one value per negedge; spike forces a 1 at that step.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int spike);
    for (int n = 0; n < FRAME; n++) begin
      int bit_no;
      bit_no = n / CPB;
      if (bit_no == 0)      midi_rx = 1'b0;
      else if (bit_no <= 8) midi_rx = b[bit_no-1];
      else                  midi_rx = stop;
      if (n == spike) midi_rx = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic expect_one_byte(input string name, input int start, input logic [7:0] exp);
    vectors++;
    if (rdy_t.size() !== 1) begin
      miscompares++;
      $display("FAIL %s pulse count: got %0d expected 1", name, rdy_t.size());
    end else begin
      vectors++;
      if (rdy_t[0] !== start + LAT) begin
        miscompares++;
        $display("FAIL %s pulse time: got %0d expected %0d", name, rdy_t[0] - start, LAT);
      end
      vectors++;
      if (rdy_d[0] !== exp) begin
        miscompares++;
        $display("FAIL %s data: got %02h expected %02h", name, rdy_d[0], exp);
      end
    end
    vectors++;
    if (fe_t.size() !== 0) begin
      miscompares++;
      $display("FAIL %s framing_error pulses: got %0d expected 0", name, fe_t.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    midi_rx = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({data_out, data_out_ready, framing_error, busy} !== 11'h000) begin
      miscompares++;
      $display("FAIL reset outputs: got data=%02h rdy=%b fe=%b busy=%b expected 00 0 0 0",
               data_out, data_out_ready, framing_error, busy);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int start;
    repeat (50) @(negedge clk);
    clear_log();
    start = edge_cnt;
    send_frame(8'hB0, 1'b1, -1);
    repeat (20) @(negedge clk);
    expect_one_byte("single", start, 8'hB0);
    vectors++;
    if (rise_t.size() < 1 || rise_t[0] !== start + 3) begin
      miscompares++;
      $display("FAIL single busy rise: got %0d expected %0d", rise_t.size() ? rise_t[0] - start : -1, 3);
    end
    vectors++;
    if (fall_t.size() < 1 || fall_t[0] !== start + LAT) begin
      miscompares++;
      $display("FAIL single busy fall: got %0d expected %0d", fall_t.size() ? fall_t[0] - start : -1, LAT);
    end
    vectors++;
    if (data_out !== 8'hB0) begin
      miscompares++;
      $display("FAIL single data held: got %02h expected b0", data_out);
    end
  endtask

  task automatic test_back_to_back();
    int start;
    logic [7:0] bytes [3];
    bytes[0] = 8'hB0; bytes[1] = 8'h01; bytes[2] = 8'h0A;
    clear_log();
    start = edge_cnt;
    for (int k = 0; k < 3; k++) send_frame(bytes[k], 1'b1, -1);
    repeat (20) @(negedge clk);
    vectors++;
    if (rdy_t.size() !== 3) begin
      miscompares++;
      $display("FAIL b2b pulse count: got %0d expected 3", rdy_t.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (rdy_t[k] !== start + LAT + k * FRAME || rdy_d[k] !== bytes[k]) begin
          miscompares++;
          $display("FAIL b2b frame %0d: got t=%0d d=%02h expected t=%0d d=%02h",
                   k, rdy_t[k] - start, rdy_d[k], LAT + k * FRAME, bytes[k]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int start;
    repeat (20) @(negedge clk);
    clear_log();
    start = edge_cnt;
    for (int n = 0; n < HALF + 2 * CPB; n++) begin
      midi_rx = (n < CPB / 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (edge_cnt - start == HALF + 2) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL glitch busy before decision: got %b expected 1", busy);
        end
      end
      if (edge_cnt - start == HALF + 3) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL glitch back to idle: got busy=%b expected 0", busy);
        end
      end
    end
    vectors++;
    if (rdy_t.size() + fe_t.size() !== 0) begin
      miscompares++;
      $display("FAIL glitch pulses: got %0d expected 0", rdy_t.size() + fe_t.size());
    end
    clear_log();
    start = edge_cnt;
    send_frame(8'h7F, 1'b1, -1);
    repeat (20) @(negedge clk);
    expect_one_byte("after_glitch", start, 8'h7F);
  endtask

  task automatic test_framing();
    int start;
    clear_log();
    start = edge_cnt;
    send_frame(8'h55, 1'b0, -1);
    repeat (CPB * 3) @(negedge clk);
    vectors++;
    if (fe_t.size() !== 1 || fe_t[0] !== start + LAT) begin
      miscompares++;
      $display("FAIL framing pulse: got n=%0d t=%0d expected n=1 t=%0d",
               fe_t.size(), fe_t.size() ? fe_t[0] - start : -1, LAT);
    end
    vectors++;
    if (rdy_t.size() !== 0 || data_out !== 8'h7F) begin
      miscompares++;
      $display("FAIL framing data kept: got n=%0d d=%02h expected n=0 d=7f", rdy_t.size(), data_out);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL framing busy in break: got %b expected 1", busy);
    end
    midi_rx = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL framing busy release: got %b expected 0", busy);
    end
    repeat (20) @(negedge clk);
    clear_log();
    start = edge_cnt;
    send_frame(8'h3C, 1'b1, -1);
    repeat (20) @(negedge clk);
    expect_one_byte("after_break", start, 8'h3C);
  endtask

  task automatic test_reset_mid_frame();
    int start;
    logic [7:0] b;
    b = 8'hA5;
    clear_log();
    for (int n = 0; n < 4 * CPB; n++) begin
      midi_rx = (n < CPB) ? 1'b0 : b[n / CPB - 1];
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({data_out, data_out_ready, framing_error, busy} !== 11'h000) begin
      miscompares++;
      $display("FAIL midreset outputs: got data=%02h rdy=%b fe=%b busy=%b expected 00 0 0 0",
               data_out, data_out_ready, framing_error, busy);
    end
    midi_rx = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    vectors++;
    if (rdy_t.size() + fe_t.size() !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset aborted frame: got pulses=%0d busy=%b expected 0 0",
               rdy_t.size() + fe_t.size(), busy);
    end
    clear_log();
    start = edge_cnt;
    send_frame(8'h90, 1'b1, -1);
    repeat (20) @(negedge clk);
    expect_one_byte("after_reset", start, 8'h90);
  endtask

  task automatic test_spike();
    int start;
    logic [7:0] exp;
`ifdef MIDI_RX_MAJORITY_VOTE_EN
    exp = 8'h00;
`else
    exp = 8'h08;
`endif
    repeat (20) @(negedge clk);
    clear_log();
    start = edge_cnt;
    send_frame(8'h00, 1'b1, HALF + 4 * CPB);
    repeat (20) @(negedge clk);
    expect_one_byte("spike", start, exp);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid_frame();
    test_spike();
    vectors++;
    if (overlap !== 0) begin
      miscompares++;
      $display("FAIL ready/framing overlap: got %0d expected 0", overlap);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
